// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Optional feature macro used by the timer: AUTO_RELOAD_EN.
package bcd_timer_pkg;

  localparam int                  DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0]  BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Non-decimal nibbles saturate to 9 so the counter never holds an illegal digit.
  function automatic logic [DIGIT_W-1:0] clamp_bcd(input logic [DIGIT_W-1:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Host-side bus of the BCD countdown timer: tick strobe, preset handshake,
// run control and status. master = host/prescaler side, slave = timer.
interface bcd_countdown_timer_if
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS = 4
);
  logic                       tick;
  logic                       load_valid;
  logic [DIGITS*DIGIT_W-1:0]  load_value;
  logic                       load_ready;
  logic                       start;
  logic                       pause;
  logic [DIGITS*DIGIT_W-1:0]  count;
  logic                       running;
  logic                       zero;
  logic                       done;

  modport master (
    output tick, load_valid, load_value, start, pause,
    input  load_ready, count, running, zero, done
  );

  modport slave (
    input  tick, load_valid, load_value, start, pause,
    output load_ready, count, running, zero, done
  );
endinterface

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD digit of the down-counter: parallel load, or decrement 9..0 when a
// borrow arrives from below, passing a borrow upward when it wraps 0 -> 9.
module bcd_down_digit
  import bcd_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_val_i,
  input  logic               borrow_i,
  output logic               borrow_o,
  output logic [DIGIT_W-1:0] digit_o
);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  // Load beats decrement; a borrow into a 0 digit wraps it to 9.
  always_comb begin
    digit_d = digit_q;
    if (load_i)        digit_d = load_val_i;
    else if (borrow_i) digit_d = (digit_q == '0) ? BCD_MAX : digit_q - DIGIT_W'(1);
  end

  // Digit register, cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign borrow_o = borrow_i & (digit_q == '0);
  assign digit_o  = digit_q;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer: preset handshake, start/pause/resume FSM,
// one-cycle done pulse at terminal count.
// AUTO_RELOAD_EN: when defined, terminal count reloads the last accepted
// preset and the timer keeps running instead of stopping in DONE.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS = 4
)(
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_countdown_timer_if.slave  bus
);

  localparam int CW = DIGITS * DIGIT_W;

  state_e                         state_q, state_d;
  logic                           done_q, done_d;
  logic [DIGITS-1:0][DIGIT_W-1:0] digits, load_clamp, ld_val;
  logic [CW-1:0]                  count_flat;
  logic                           ld_en, dec_en, accept, is_zero, is_one;
  logic [DIGITS:0]                borrow;
  logic                           unused_borrow;

  assign count_flat = digits;
  assign is_zero    = (count_flat == '0);
  assign is_one     = (count_flat == CW'(1));
  assign accept     = bus.load_valid & bus.load_ready;

  // Saturate every preset nibble to a legal decimal digit.
  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      load_clamp[i] = clamp_bcd(bus.load_value[i*DIGIT_W +: DIGIT_W]);
  end

`ifdef AUTO_RELOAD_EN
  logic [DIGITS-1:0][DIGIT_W-1:0] reload_q;

  // Remember the last accepted preset as the auto-reload period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      reload_q <= '0;
    else if (accept) reload_q <= load_clamp;
  end
`endif

  // Next state, digit load/decrement control and done pulse.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    ld_en   = 1'b0;
    ld_val  = load_clamp;
    dec_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) ld_en = 1'b1;
        else if (bus.start && !bus.pause) begin
          if (is_zero) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // A tick coinciding with pause is dropped; zero guard stops wrap.
        if (bus.pause) state_d = PAUSED;
        else if (bus.tick && !is_zero) begin
          dec_en = 1'b1;
          if (is_one) begin
            done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
            dec_en = 1'b0;
            ld_en  = 1'b1;
            ld_val = reload_q;
`else
            state_d = DONE;
`endif
          end
        end
      end
      PAUSED: begin
        if (accept) begin
          ld_en   = 1'b1;
          state_d = IDLE;
        end else if (bus.start && !bus.pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (accept) begin
          ld_en   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // done is strictly a single-cycle pulse, even with back-to-back terminals.
    if (done_q) done_d = 1'b0;
  end

  // FSM state and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign borrow[0] = dec_en;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (ld_en),
      .load_val_i (ld_val[g]),
      .borrow_i   (borrow[g]),
      .borrow_o   (borrow[g+1]),
      .digit_o    (digits[g])
    );
  end

  // Top borrow would mean decrementing from zero, which the FSM never allows.
  assign unused_borrow = borrow[DIGITS];

  assign bus.count      = digits;
  assign bus.zero       = is_zero;
  assign bus.running    = (state_q == RUN);
  assign bus.done       = done_q;
  assign bus.load_ready = (state_q != RUN);

endmodule
